dbus_fabric: RTL and testbench

Parametrised data-bus interconnect between the cpu_2432 data port and N memory-mapped slaves (RAM, GPIO, future UART/timer). Successor to the fixed two-way RAM/GPIO read multiplexer: N-way address decode, registered request capture, per-slave ready handshake, timeout and unmapped-address error reporting. Sits between the CPU data port and the slave array in the system top.

---
 rtl/dbus_pkg.sv | 18 +
 rtl/dbus_rdmux.sv | 26 ++
 rtl/dbus_fabric.sv | 140 ++++++++++++++
 tb/tb_dbus_fabric.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_pkg.sv
// Shared definitions for the CPU data-bus fabric: FSM state encoding,
// the read data returned on error, and the slave-select field width helper.
package dbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Read data returned with an error ack (unmapped address or timeout).
  localparam int unsigned UNMAPPED_RDATA = 0;

  function automatic int sel_width(input int msb, input int lsb);
    return msb - lsb + 1;
  endfunction

endpackage

// File: rtl/dbus_rdmux.sv
// NSLAVES-way read-data select: picks slave k's word from the packed
// read-data bus when the select index equals k.
module dbus_rdmux
  import dbus_pkg::*;
#(
  parameter int NSLAVES = 3,
  parameter int DW      = 32,
  parameter int SW      = 2
) (
  input  logic [SW-1:0]         i_sel,
  input  logic [NSLAVES*DW-1:0] i_rdata,
  output logic [DW-1:0]         o_rdata
);

  always_comb begin
    // NOTE: default assignment first so no path through the loop leaves
    // o_rdata unassigned, which would otherwise infer a latch.
    o_rdata = DW'(UNMAPPED_RDATA);
    for (int k = 0; k < NSLAVES; k++) begin
      if (i_sel == SW'(k)) begin
        o_rdata = i_rdata[k*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/dbus_fabric.sv
// Data-bus interconnect between the CPU data port and N memory-mapped slaves:
// address decode, registered request capture, ready handshake, error reporting.
module dbus_fabric
  import dbus_pkg::*;
#(
  parameter int AW      = 24,
  parameter int DW      = 32,
  parameter int NSLAVES = 3,
  parameter int SEL_MSB = 23,
  parameter int SEL_LSB = 22,
  parameter int TIMEOUT = 15
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clk_en,
  input  logic [AW-1:0]         i_m_addr,
  input  logic [DW-1:0]         i_m_wdata,
  input  logic                  i_m_rd,
  input  logic [DW/8-1:0]       i_m_wr,
  output logic [DW-1:0]         o_m_rdata,
  output logic                  o_m_ack,
  output logic                  o_m_err,
  output logic                  o_m_busy,
  output logic [AW-1:0]         o_s_addr,
  output logic [DW-1:0]         o_s_wdata,
  output logic [NSLAVES-1:0]    o_s_cs,
  output logic                  o_s_rd,
  output logic [DW/8-1:0]       o_s_wr,
  input  logic [NSLAVES*DW-1:0] i_s_rdata,
  input  logic [NSLAVES-1:0]    i_s_rdy
);

  localparam int SW = sel_width(SEL_MSB, SEL_LSB);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e              r_state;
  logic [SW-1:0]       r_idx;
  logic [CW-1:0]       r_cnt;

  logic                w_req;
  logic [SW-1:0]       w_req_idx;
  logic                w_mapped;
  logic [NSLAVES-1:0]  w_req_cs;
  logic                w_sel_rdy;
  logic [DW-1:0]       w_sel_rdata;

  assign w_req     = i_m_rd | (|i_m_wr);
  assign w_req_idx = i_m_addr[SEL_MSB:SEL_LSB];
  assign w_mapped  = ({1'b0, w_req_idx} < (SW+1)'(NSLAVES));
  assign w_req_cs  = NSLAVES'(1) << w_req_idx;
  // o_s_cs is one-hot during ACCESS, so masking the ready bus with it
  // selects the addressed slave's ready without an out-of-range index.
  assign w_sel_rdy = |(i_s_rdy & o_s_cs);

  dbus_rdmux #(
    .NSLAVES (NSLAVES),
    .DW      (DW),
    .SW      (SW)
  ) u_rdmux (
    .i_sel   (r_idx),
    .i_rdata (i_s_rdata),
    .o_rdata (w_sel_rdata)
  );

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every register samples pre-edge values and simulation matches hardware.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_cnt     <= '0;
      o_m_rdata <= DW'(UNMAPPED_RDATA);
      o_m_ack   <= 1'b0;
      o_m_err   <= 1'b0;
      o_m_busy  <= 1'b0;
      o_s_addr  <= '0;
      o_s_wdata <= '0;
      o_s_cs    <= '0;
      o_s_rd    <= 1'b0;
      o_s_wr    <= '0;
    end else if (i_clk_en) begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            o_s_addr  <= i_m_addr;
            o_s_wdata <= i_m_wdata;
            r_idx     <= w_req_idx;
            r_cnt     <= '0;
            o_m_busy  <= 1'b1;
            if (w_mapped) begin
              o_s_cs  <= w_req_cs;
              // A write beats a simultaneous read.
              o_s_rd  <= i_m_rd & ~(|i_m_wr);
              o_s_wr  <= i_m_wr;
              r_state <= ST_ACCESS;
            end else begin
              o_m_err   <= 1'b1;
              o_m_ack   <= 1'b1;
              o_m_rdata <= DW'(UNMAPPED_RDATA);
              r_state   <= ST_RESP;
            end
          end
        end

        ST_ACCESS: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_sel_rdy || (r_cnt == CW'(TIMEOUT - 1))) begin
            o_s_cs  <= '0;
            o_s_rd  <= 1'b0;
            o_s_wr  <= '0;
            o_m_ack <= 1'b1;
            r_state <= ST_RESP;
            if (w_sel_rdy) begin
              o_m_err <= 1'b0;
              if (o_s_rd) begin
                o_m_rdata <= w_sel_rdata;
              end
            end else begin
              o_m_err   <= 1'b1;
              o_m_rdata <= DW'(UNMAPPED_RDATA);
            end
          end
        end

        ST_RESP: begin
          o_m_ack  <= 1'b0;
          o_m_err  <= 1'b0;
          o_m_busy <= 1'b0;
          r_cnt    <= '0;
          r_state  <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_fabric.sv
// Self-checking bench for dbus_fabric: transaction-level expectation model
// compared against every DUT output on every falling clock edge.
module tb_dbus_fabric;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam int NS = 3;
  localparam int TO = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            clk_en = 1'b1;
  logic [AW-1:0]   m_addr = '0;
  logic [DW-1:0]   m_wdata = '0;
  logic            m_rd = 1'b0;
  logic [3:0]      m_wr = '0;
  logic [DW-1:0]   m_rdata;
  logic            m_ack, m_err, m_busy;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [NS-1:0]   s_cs;
  logic            s_rd;
  logic [3:0]      s_wr;
  logic [NS*DW-1:0] s_rdata = '0;
  logic [NS-1:0]   s_rdy = '0;

  dbus_fabric #(
    .AW(AW), .DW(DW), .NSLAVES(NS), .SEL_MSB(23), .SEL_LSB(22), .TIMEOUT(TO)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_clk_en  (clk_en),
    .i_m_addr  (m_addr),
    .i_m_wdata (m_wdata),
    .i_m_rd    (m_rd),
    .i_m_wr    (m_wr),
    .o_m_rdata (m_rdata),
    .o_m_ack   (m_ack),
    .o_m_err   (m_err),
    .o_m_busy  (m_busy),
    .o_s_addr  (s_addr),
    .o_s_wdata (s_wdata),
    .o_s_cs    (s_cs),
    .o_s_rd    (s_rd),
    .o_s_wr    (s_wr),
    .i_s_rdata (s_rdata),
    .i_s_rdy   (s_rdy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int ncyc = 0;
  int ack_count = 0;
  int ack_at = -1;
  int req_at = 0;
  bit prev_ack = 1'b0;
  bit cmp_en = 1'b1;

  // Expected outputs, maintained at transaction level by the driver.
  logic [DW-1:0] exp_rdata = '0;
  logic          exp_ack = 1'b0, exp_err = 1'b0, exp_busy = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
  logic [NS-1:0] exp_cs = '0;
  logic          exp_rd = 1'b0;
  logic [3:0]    exp_wr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, ncyc);
    end
  endtask

  always @(posedge clk) ncyc <= ncyc + 1;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_rdata", 64'(m_rdata), 64'(exp_rdata));
      check("m_ack",   64'(m_ack),   64'(exp_ack));
      check("m_err",   64'(m_err),   64'(exp_err));
      check("m_busy",  64'(m_busy),  64'(exp_busy));
      check("s_addr",  64'(s_addr),  64'(exp_addr));
      check("s_wdata", 64'(s_wdata), 64'(exp_wdata));
      check("s_cs",    64'(s_cs),    64'(exp_cs));
      check("s_rd",    64'(s_rd),    64'(exp_rd));
      check("s_wr",    64'(s_wr),    64'(exp_wr));
      if (m_ack === 1'b1 && !prev_ack) begin
        ack_count++;
        ack_at = ncyc;
      end
      prev_ack = (m_ack === 1'b1);
    end
  end

  // One complete master transaction. rdy_dly: enabled ACCESS cycles before the
  // selected slave answers (>= TO means it never does). stall_at/stall_len:
  // clock-enable gap inserted at that ACCESS cycle. spurious: a second request
  // presented while busy, which must be dropped.
  task automatic do_txn(input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic rd, input logic [3:0] wr, input int rdy_dly,
                        input logic [DW-1:0] sdata, input int stall_at,
                        input int stall_len, input bit spurious);
    int  idx;
    int  k;
    int  stalled;
    bit  en;
    bit  done;
    bit  timed_out;
    idx = int'(addr[23:22]);
    m_addr = addr; m_wdata = wdata; m_rd = rd; m_wr = wr;
    clk_en = 1'b1;
    req_at = ncyc;
    @(posedge clk); #1;
    m_rd = 1'b0; m_wr = '0; m_addr = AW'($urandom); m_wdata = $urandom;
    exp_addr = addr; exp_wdata = wdata; exp_busy = 1'b1;
    if (idx >= NS) begin
      exp_ack = 1'b1; exp_err = 1'b1; exp_rdata = '0;
    end else begin
      exp_cs = NS'(1) << idx;
      exp_rd = rd && (wr == 4'b0);
      exp_wr = wr;
      k = 0; stalled = 0; done = 1'b0; timed_out = 1'b0;
      while (!done) begin
        if (spurious && k == 0) begin
          m_rd = 1'b1; m_wr = 4'($urandom); m_addr = AW'($urandom);
        end else begin
          m_rd = 1'b0; m_wr = '0;
        end
        s_rdata = {$urandom, $urandom, $urandom};
        s_rdy = NS'($urandom);
        s_rdy[idx] = 1'b0;
        if (k == stall_at && stalled < stall_len) begin
          clk_en = 1'b0;
          stalled++;
        end else begin
          clk_en = 1'b1;
          if (k == rdy_dly) begin
            s_rdy[idx] = 1'b1;
            s_rdata[idx*DW +: DW] = sdata;
          end
        end
        en = clk_en;
        @(posedge clk); #1;
        if (en) begin
          if (k == rdy_dly) begin
            done = 1'b1;
          end else if (k == TO - 1) begin
            done = 1'b1; timed_out = 1'b1;
          end
          k++;
        end
      end
      exp_cs = '0; exp_rd = 1'b0; exp_wr = '0;
      exp_ack = 1'b1; exp_err = timed_out;
      if (timed_out) exp_rdata = '0;
      else if (rd && wr == 4'b0) exp_rdata = sdata;
    end
    clk_en = 1'b1; s_rdy = '0; m_rd = 1'b0; m_wr = '0;
    @(posedge clk); #1;
    exp_ack = 1'b0; exp_err = 1'b0; exp_busy = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, ncyc=%0d", ncyc);
    $fatal(1);
  end

  initial begin
    int acks0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Read slave 0, ready at first ACCESS cycle.
    do_txn(24'h000010, 32'h0, 1'b1, 4'b0000, 0, 32'hCAFEF00D, -1, 0, 1'b0);
    check("rd0_latency", 64'(ack_at - req_at), 64'd2);
    check("rd0_rdata", 64'(m_rdata), 64'hCAFEF00D);

    // Byte write slave 1, ready after 3 cycles; rdata must be untouched.
    do_txn(24'h400004, 32'h00AB0000, 1'b0, 4'b0100, 3, 32'h12345678, -1, 0, 1'b0);
    check("wr1_latency", 64'(ack_at - req_at), 64'd5);
    check("wr1_rdata_kept", 64'(m_rdata), 64'hCAFEF00D);

    // Unmapped index 3.
    do_txn(24'hC00000, 32'h0, 1'b1, 4'b0000, 0, 32'h0, -1, 0, 1'b0);
    check("unmapped_latency", 64'(ack_at - req_at), 64'd1);
    check("unmapped_rdata", 64'(m_rdata), 64'd0);

    // Timeout on slave 2.
    do_txn(24'h800000, 32'h0, 1'b1, 4'b0000, 100, 32'h0, -1, 0, 1'b0);
    check("timeout_latency", 64'(ack_at - req_at), 64'd16);

    // Ready on the last allowed cycle wins over timeout.
    do_txn(24'h800008, 32'h0, 1'b1, 4'b0000, TO - 1, 32'h0BADBEEF, -1, 0, 1'b0);
    check("edge_latency", 64'(ack_at - req_at), 64'd16);
    check("edge_rdata", 64'(m_rdata), 64'h0BADBEEF);

    // Read+write together, with a dropped request while busy.
    acks0 = ack_count;
    do_txn(24'h400100, 32'hFFFF0000, 1'b1, 4'b1111, 1, 32'h55555555, -1, 0, 1'b1);
    repeat (3) @(posedge clk);
    #1 check("busy_one_ack", 64'(ack_count - acks0), 64'd1);
    check("busy_rdata_kept", 64'(m_rdata), 64'h0BADBEEF);

    // Five-cycle clock-enable stall during a timeout: no timeout progress.
    do_txn(24'h000040, 32'h0, 1'b1, 4'b0000, 100, 32'h0, 2, 5, 1'b0);
    check("stall_latency", 64'(ack_at - req_at), 64'd21);

    // Reset mid-ACCESS: strobes drop at once, no ack.
    m_addr = 24'h000020; m_wdata = 32'h13572468; m_rd = 1'b1;
    @(posedge clk); #1;
    m_rd = 1'b0;
    exp_addr = 24'h000020; exp_wdata = 32'h13572468;
    exp_cs = 3'b001; exp_rd = 1'b1; exp_busy = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    acks0 = ack_count;
    rst = 1'b1;
    exp_cs = '0; exp_rd = 1'b0; exp_wr = '0; exp_busy = 1'b0; exp_ack = 1'b0;
    exp_err = 1'b0; exp_rdata = '0; exp_addr = '0; exp_wdata = '0;
    #1 check("rst_cs_async", 64'(s_cs), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("rst_no_ack", 64'(ack_count - acks0), 64'd0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      logic [AW-1:0] a;
      logic          r;
      logic [3:0]    w;
      int            dly;
      int            sa;
      a = AW'($urandom);
      r = 1'($urandom);
      w = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      if (!r && w == 4'b0) r = 1'b1;
      case ($urandom_range(0, 5))
        0:       dly = TO - 1;
        1:       dly = TO + 3;
        default: dly = int'($urandom_range(0, 5));
      endcase
      sa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
      do_txn(a, $urandom, r, w, dly, $urandom, sa, int'($urandom_range(1, 4)),
             1'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
